pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 3-stage core (pc_reg -> if_id -> id_ex -> ex).
- Generates the PC hold, PC redirect and per-stage flush-to-NOP flags that drive the hold_flag_i inputs of if_id and id_ex.
- Handles three request sources: taken jumps/branches from ex, multi-cycle divide from ex, and instruction-bus wait states.
- Contains a small FSM plus a bubble counter and a latched return address.

Parameters:
ADDR_W, 32, width of PC/jump addresses
FLUSH_CYCLES, 1, bubbles inserted after a taken jump (legal 1..15)
CNT_W, 4, width of bubble counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
jump_en_i  in  1  ex: taken branch/jal/jalr, single-cycle pulse
jump_addr_i  in  ADDR_W  ex: jump target, valid with jump_en_i
div_start_i  in  1  ex: divide issued, single-cycle pulse
div_pc_i  in  ADDR_W  ex: address of the divide instruction, valid with div_start_i
div_done_i  in  1  ex: divide result written, single-cycle pulse
mem_wait_i  in  1  instruction bus not ready this cycle
jump_en_o  out  1  to pc_reg: load jump_addr_o
jump_addr_o  out  ADDR_W  to pc_reg: redirect target
hold_pc_o  out  1  to pc_reg: keep current PC
flush_if_id_o  out  1  to if_id hold_flag_i (loads INST_NOP, addr 0)
flush_id_ex_o  out  1  to id_ex hold_flag_i (loads NOP)

Behaviour:
- Registers: state, cnt (CNT_W), ret_addr (ADDR_W). All are cleared asynchronously when rst=0: state=RUN, cnt=0, ret_addr=0.
- While rst=0, outputs are forced to: jump_en_o=0, jump_addr_o=0, hold_pc_o=0, flush_if_id_o=1, flush_id_ex_o=1.
- Outputs are combinational from state and inputs, so there is zero-cycle latency to pc_reg and the pipe registers. State updates on the posedge.
- Defaults, unless a case below overrides them: all outputs 0, jump_addr_o=0.

State RUN:
- jump_en_i=1 (highest priority):
  - Drive jump_en_o=1, jump_addr_o=jump_addr_i, both flushes=1, hold_pc_o=0.
  - If FLUSH_CYCLES>1: cnt<=FLUSH_CYCLES-1 and go to FLUSH. Otherwise stay in RUN.
  - A div_start_i or mem_wait_i in the same cycle is ignored.
- else div_start_i=1:
  - ret_addr<=div_pc_i+4, modulo 2^ADDR_W, so wrap-around is allowed.
  - Drive hold_pc_o=1 and both flushes=1, then go to DIV_WAIT.
- else mem_wait_i=1: hold_pc_o=1, flush_if_id_o=1, flush_id_ex_o=0 (bubble enters decode).
- else all outputs 0.

State FLUSH:
- Both flushes=1, hold_pc_o=0.
- cnt decrements each cycle; when cnt==1 on a cycle, go to RUN next.
- jump_en_i=1: honour it as in RUN (redirect, flushes) and reload cnt=FLUSH_CYCLES-1.
- div_start_i and mem_wait_i are ignored.

State DIV_WAIT:
- hold_pc_o=1, both flushes=1 every cycle.
- div_done_i=1: drive jump_en_o=1, jump_addr_o=ret_addr, hold_pc_o=0, both flushes=1, then go to RUN.
- jump_en_i, div_start_i and mem_wait_i are ignored.
- There is no timeout; the divider guarantees completion.

General:
- div_done_i outside DIV_WAIT is ignored.
- Reset asserted mid-DIV_WAIT or mid-FLUSH returns to RUN; ret_addr and cnt are discarded.
- Invariant: jump_en_o and hold_pc_o are never 1 in the same cycle.

Optional Feature:
Macro: PIPE_CTRL_STAT_EN
- Defined:
  - Adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments each cycle that hold_pc_o=1.
  - flush_cnt_o increments each cycle that flush_id_ex_o=1 while rst=1.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared defines header:
  - state encodings: ST_RUN=2'd0, ST_FLUSH=2'd1, ST_DIV_WAIT=2'd2.
  - ZERO_WORD.
  - INST_NOP (already present there).
- Sub-module: pipe_ctrl_cnt, the loadable down-counter with a zero flag, reused for the bubble count.
  - When PIPE_CTRL_STAT_EN is defined, stat counters are instantiated inline as saturating up-counters.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with jump_en_i=1 -> jump_en_o=0, flushes=1, hold_pc_o=0. After release -> state RUN and all outputs 0.
2. Jump, FLUSH_CYCLES=1: jump_en_i=1, jump_addr_i=32'h100 -> same cycle jump_en_o=1, jump_addr_o=32'h100, flushes=1. Next cycle all 0.
3. Jump, FLUSH_CYCLES=3: jump to 32'h200 -> flushes=1 for 3 consecutive cycles, jump_en_o=1 only in the first, RUN on the 4th. A second jump to 32'h300 in cycle 2 -> redirect to 32'h300 and counter reloads.
4. Divide: div_start_i with div_pc_i=32'h40, div_done_i 10 cycles later -> hold_pc_o=1 and flushes=1 for 11 cycles, then jump_en_o=1, jump_addr_o=32'h44. A jump_en_i injected mid-wait is ignored.
5. Wrap and reset: div_pc_i=32'hFFFFFFFC -> jump_addr_o=32'h0 on done. Repeat with rst pulsed low mid-wait -> back to RUN, and a later div_done_i is ignored.
6. Bus wait: mem_wait_i=1 for 4 cycles -> hold_pc_o=1, flush_if_id_o=1, flush_id_ex_o=0. jump_en_i together with mem_wait_i -> jump_en_o=1, hold_pc_o=0. With PIPE_CTRL_STAT_EN defined, stall_cnt_o counts exactly 4.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and constants for the pipeline sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// rtl/pipe_ctrl_cnt.sv - loadable down-counter with zero flag, used for the jump bubble count
module pipe_ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load_en) begin
      cnt <= load_val;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - PC hold/redirect and flush-to-NOP sequencer for the 3-stage core
// Optional statistics counters are enabled with PIPE_CTRL_STAT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              div_start_i,
  input  logic [ADDR_W-1:0] div_pc_i,
  input  logic              div_done_i,
  input  logic              mem_wait_i,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              hold_pc_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o
`ifdef PIPE_CTRL_STAT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] RELOAD      = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam bit               MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_t            state;
  state_t            nxt_state;
  logic [ADDR_W-1:0] ret_addr;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;
  logic              cnt_load;
  logic              cnt_dec;
  logic              ret_load;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              hold_pc;
  logic              flush_if_id;
  logic              flush_id_ex;

  pipe_ctrl_cnt #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_en (cnt_load),
    .load_val(RELOAD),
    .dec_en  (cnt_dec),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  always_comb begin
    jump_en     = 1'b0;
    jump_addr   = '0;
    hold_pc     = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    nxt_state   = state;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    ret_load    = 1'b0;
    case (state)
      ST_RUN: begin
        if (jump_en_i) begin
          jump_en     = 1'b1;
          jump_addr   = jump_addr_i;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (MULTI_FLUSH) begin
            cnt_load  = 1'b1;
            nxt_state = ST_FLUSH;
          end
        end else if (div_start_i) begin
          ret_load    = 1'b1;
          hold_pc     = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          nxt_state   = ST_DIV_WAIT;
        end else if (mem_wait_i) begin
          // Fetch stalls but decode drains: a bubble enters id_ex.
          hold_pc     = 1'b1;
          flush_if_id = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (jump_en_i) begin
          jump_en   = 1'b1;
          jump_addr = jump_addr_i;
          cnt_load  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_zero || (cnt == CNT_ONE)) begin
            nxt_state = ST_RUN;
          end
        end
      end
      ST_DIV_WAIT: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (div_done_i) begin
          jump_en   = 1'b1;
          jump_addr = ret_addr;
          nxt_state = ST_RUN;
        end else begin
          hold_pc = 1'b1;
        end
      end
      default: nxt_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      ret_addr <= ADDR_W'(ZERO_WORD);
    end else begin
      state <= nxt_state;
      if (ret_load) begin
        ret_addr <= div_pc_i + ADDR_W'(4);
      end
    end
  end

  // Reset keeps the pipe registers loading NOPs and the PC untouched.
  assign jump_en_o     = rst & jump_en;
  assign jump_addr_o   = rst ? jump_addr : '0;
  assign hold_pc_o     = rst & hold_pc;
  assign flush_if_id_o = ~rst | flush_if_id;
  assign flush_id_ex_o = ~rst | flush_id_ex;

`ifdef PIPE_CTRL_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hold_pc_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (flush_id_ex_o && (flush_cnt_o != 32'hFFFF_FFFF)) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl, FLUSH_CYCLES 1 and 3 side by side
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        div_start_i = 1'b0;
  logic [31:0] div_pc_i = '0;
  logic        div_done_i = 1'b0;
  logic        mem_wait_i = 1'b0;

  logic        a_je, a_hp, a_fi, a_fe;
  logic [31:0] a_ja;
  logic        b_je, b_hp, b_fi, b_fe;
  logic [31:0] b_ja;
`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(1), .CNT_W(4)) dut_f1 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .div_start_i(div_start_i), .div_pc_i(div_pc_i), .div_done_i(div_done_i),
    .mem_wait_i(mem_wait_i), .jump_en_o(a_je), .jump_addr_o(a_ja), .hold_pc_o(a_hp),
    .flush_if_id_o(a_fi), .flush_id_ex_o(a_fe)
`ifdef PIPE_CTRL_STAT_EN
    , .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
`endif
  );

  pipe_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(3), .CNT_W(4)) dut_f3 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .div_start_i(div_start_i), .div_pc_i(div_pc_i), .div_done_i(div_done_i),
    .mem_wait_i(mem_wait_i), .jump_en_o(b_je), .jump_addr_o(b_ja), .hold_pc_o(b_hp),
    .flush_if_id_o(b_fi), .flush_id_ex_o(b_fe)
`ifdef PIPE_CTRL_STAT_EN
    , .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining bubbles after a jump, divide-pending flag, return address.
  int          m_f[2] = '{1, 3};
  int          m_left[2];
  bit          m_div[2];
  logic [31:0] m_ret[2];
  longint      m_stall[2];
  longint      m_flush[2];

  // Snapshot of flags {jump_en, hold_pc, flush_if_id, flush_id_ex} and address, taken mid-cycle.
  logic [3:0]  s_out[2];
  logic [31:0] s_addr[2];
  logic [31:0] s_stall[2];

  function automatic void model_out(input int k, output logic [3:0] f, output logic [31:0] a);
    f = 4'b0000;
    a = 32'h0;
    if (!rst) f = 4'b0011;
    else if (m_div[k]) begin
      if (div_done_i) begin f = 4'b1011; a = m_ret[k]; end
      else f = 4'b0111;
    end else if (jump_en_i) begin f = 4'b1011; a = jump_addr_i; end
    else if (m_left[k] > 0) f = 4'b0011;
    else if (div_start_i) f = 4'b0111;
    else if (mem_wait_i) f = 4'b0110;
  endfunction

  function automatic void model_adv(input int k);
    if (!rst) begin
      m_div[k] = 1'b0;
      m_left[k] = 0;
    end else if (m_div[k]) begin
      if (div_done_i) m_div[k] = 1'b0;
    end else if (jump_en_i) m_left[k] = m_f[k] - 1;
    else if (m_left[k] > 0) m_left[k]--;
    else if (div_start_i) begin
      m_div[k] = 1'b1;
      m_ret[k] = div_pc_i + 32'd4;
    end
  endfunction

  task automatic step();
    logic [3:0]  eo;
    logic [31:0] ea;
    @(negedge clk);
    s_out[0] = {a_je, a_hp, a_fi, a_fe};
    s_addr[0] = a_ja;
    s_out[1] = {b_je, b_hp, b_fi, b_fe};
    s_addr[1] = b_ja;
    s_stall[0] = '0;
    s_stall[1] = '0;
    for (int k = 0; k < 2; k++) begin
      model_out(k, eo, ea);
      chk($sformatf("flags_f%0d", m_f[k]), s_out[k], eo);
      chk($sformatf("addr_f%0d", m_f[k]), s_addr[k], ea);
`ifdef PIPE_CTRL_STAT_EN
      if (!rst) begin
        m_stall[k] = 0;
        m_flush[k] = 0;
      end
      s_stall[k] = (k == 0) ? a_stall : b_stall;
      chk($sformatf("stall_cnt_f%0d", m_f[k]), s_stall[k], m_stall[k]);
      chk($sformatf("flush_cnt_f%0d", m_f[k]), (k == 0) ? a_flush : b_flush, m_flush[k]);
      m_stall[k] += eo[2];
      m_flush[k] += (rst && eo[0]) ? 1 : 0;
`endif
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_adv(k);
    #1;
  endtask

  task automatic idle_in();
    jump_en_i = 1'b0;
    div_start_i = 1'b0;
    div_done_i = 1'b0;
    mem_wait_i = 1'b0;
  endtask

  int holds;
  logic [31:0] st0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_div[k] = 0; m_ret[k] = '0; m_stall[k] = 0; m_flush[k] = 0;
    end
    // Reset held with a jump request present
    rst = 1'b0;
    jump_en_i = 1'b1;
    jump_addr_i = 32'h123;
    repeat (3) begin
      step();
      chk("rst_flags", s_out[0], 4'b0011);
    end
    idle_in();
    rst = 1'b1;
    step();
    chk("post_rst_idle", {s_out[0], s_out[1]}, 8'h00);

    // Single-bubble jump
    jump_en_i = 1'b1; jump_addr_i = 32'h100;
    step();
    chk("j1_flags", s_out[0], 4'b1011);
    chk("j1_addr", s_addr[0], 32'h100);
    idle_in();
    step();
    chk("j1_after", s_out[0], 4'b0000);
    repeat (3) step();

    // Three-bubble jump with a second jump landing in the flush window
    jump_en_i = 1'b1; jump_addr_i = 32'h200;
    step();
    chk("j3_first", s_out[1], 4'b1011);
    idle_in();
    step();
    chk("j3_bubble", s_out[1], 4'b0011);
    jump_en_i = 1'b1; jump_addr_i = 32'h300;
    step();
    chk("j3_redirect_addr", s_addr[1], 32'h300);
    chk("j3_redirect_flags", s_out[1], 4'b1011);
    idle_in();
    step();
    step();
    chk("j3_reload_bubble", s_out[1], 4'b0011);
    step();
    chk("j3_back_to_run", s_out[1], 4'b0000);

    // Divide: start, ten waiting cycles (one with a stray jump), then done
    holds = 0;
    div_start_i = 1'b1; div_pc_i = 32'h40;
    step();
    holds += s_out[0][2];
    idle_in();
    for (int i = 0; i < 10; i++) begin
      jump_en_i = (i == 5);
      jump_addr_i = 32'hDEAD_0000;
      step();
      holds += s_out[0][2];
    end
    jump_en_i = 1'b0;
    div_done_i = 1'b1;
    step();
    chk("div_hold_cycles", holds, 11);
    chk("div_return_addr", s_addr[0], 32'h44);
    chk("div_return_flags", s_out[0], 4'b1011);
    idle_in();
    step();

    // Return-address wrap, then reset in the middle of a divide
    div_start_i = 1'b1; div_pc_i = 32'hFFFF_FFFC;
    step();
    idle_in();
    repeat (3) step();
    div_done_i = 1'b1;
    step();
    chk("wrap_addr", s_addr[1], 32'h0);
    chk("wrap_flags", s_out[1], 4'b1011);
    idle_in();
    div_start_i = 1'b1; div_pc_i = 32'h80;
    step();
    idle_in();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("div_rst_run", s_out[0], 4'b0000);
    div_done_i = 1'b1;
    step();
    chk("late_done_ignored", {s_out[0], s_out[1]}, 8'h00);
    idle_in();

    // Instruction-bus wait states
    mem_wait_i = 1'b1;
    step();
    st0 = s_stall[0];
    chk("memwait_flags", s_out[0], 4'b0110);
    repeat (3) begin
      step();
      chk("memwait_flags", s_out[1], 4'b0110);
    end
    jump_en_i = 1'b1; jump_addr_i = 32'h500;
    step();
    chk("memwait_jump_flags", s_out[0], 4'b1011);
`ifdef PIPE_CTRL_STAT_EN
    chk("memwait_stall_delta", s_stall[0] - st0, 32'd4);
`endif
    idle_in();
    repeat (4) step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 149) != 0);
      jump_en_i   = ($urandom_range(0, 7) == 0);
      jump_addr_i = $urandom;
      div_start_i = ($urandom_range(0, 9) == 0);
      div_pc_i    = $urandom;
      div_done_i  = ($urandom_range(0, 6) == 0);
      mem_wait_i  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
